// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter (FPU vs FP load) with a one-cycle
// registered write port and a per-register busy scoreboard for decode hazards.
module fp_wb_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fpu_valid,
  input  logic [4:0]  fpu_rd,
  input  logic [31:0] fpu_data,
  output logic        fpu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rs3,
  input  logic [4:0]  chk_rd,
  output logic        hazard,
  output logic        F_WE,
  output logic [4:0]  F_rd,
  output logic [31:0] F_WD,
  output logic [31:0] busy
);
  localparam int NUM_REGS = 32;
  localparam int RW       = 5;
  localparam int DW       = 32;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  wb_req_t             fpu_req, ld_req;
  wb_req_t             wb_d, wb_q;
  logic                gnt_fpu, gnt_ld, xfer;
  logic                f_we_d, f_we_q;
  logic                last_fpu_d, last_fpu_q;
  logic [NUM_REGS-1:0] busy_d, busy_q;

  assign fpu_req.rd   = fpu_rd;
  assign fpu_req.data = fpu_data;
  assign ld_req.rd    = ld_rd;
  assign ld_req.data  = ld_data;

  // Grants are gated by rst_n so no handshake can complete while in reset.
  always_comb begin
    gnt_fpu = 1'b0;
    gnt_ld  = 1'b0;
    if (rst_n) begin
      if (fpu_valid && ld_valid) begin
        if (RR_EN && last_fpu_q) gnt_ld  = 1'b1;
        else                     gnt_fpu = 1'b1;
      end else begin
        gnt_fpu = fpu_valid;
        gnt_ld  = ld_valid;
      end
    end
  end

  assign fpu_ready = gnt_fpu;
  assign ld_ready  = gnt_ld;
  assign xfer      = gnt_fpu | gnt_ld;

  always_comb begin
    f_we_d     = xfer;
    wb_d       = wb_q;
    last_fpu_d = last_fpu_q;
    if (gnt_fpu) begin
      wb_d       = fpu_req;
      last_fpu_d = 1'b1;
    end else if (gnt_ld) begin
      wb_d       = ld_req;
      last_fpu_d = 1'b0;
    end
  end

  // Clear on the edge that commits the write; a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (f_we_q)    busy_d[wb_q.rd] = 1'b0;
    if (iss_valid) busy_d[iss_rd]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_we_q     <= 1'b0;
      wb_q       <= '0;
      last_fpu_q <= 1'b0;
      busy_q     <= '0;
    end else begin
      f_we_q     <= f_we_d;
      wb_q       <= wb_d;
      last_fpu_q <= last_fpu_d;
      busy_q     <= busy_d;
    end
  end

  assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rs3] | busy_q[chk_rd];

  assign F_WE = f_we_q;
  assign F_rd = wb_q.rd;
  assign F_WD = wb_q.data;
  assign busy = busy_q;
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench: two arbiters (round-robin k=0, fixed-FPU k=1) driven by
// independent requesters, checked against a queue-based behavioural model.
module tb_fp_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       fpu_valid, ld_valid, iss_valid, fpu_ready, ld_ready, hazard, f_we;
  logic [1:0][4:0]  fpu_rd, ld_rd, iss_rd, chk_rs1, chk_rs2, chk_rs3, chk_rd, f_rd;
  logic [1:0][31:0] fpu_data, ld_data, f_wd, busy;

  fp_wb_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .fpu_valid(fpu_valid[0]), .fpu_rd(fpu_rd[0]), .fpu_data(fpu_data[0]), .fpu_ready(fpu_ready[0]),
    .ld_valid(ld_valid[0]), .ld_rd(ld_rd[0]), .ld_data(ld_data[0]), .ld_ready(ld_ready[0]),
    .iss_valid(iss_valid[0]), .iss_rd(iss_rd[0]),
    .chk_rs1(chk_rs1[0]), .chk_rs2(chk_rs2[0]), .chk_rs3(chk_rs3[0]), .chk_rd(chk_rd[0]),
    .hazard(hazard[0]), .F_WE(f_we[0]), .F_rd(f_rd[0]), .F_WD(f_wd[0]), .busy(busy[0])
  );

  fp_wb_arbiter #(.RR_EN(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .fpu_valid(fpu_valid[1]), .fpu_rd(fpu_rd[1]), .fpu_data(fpu_data[1]), .fpu_ready(fpu_ready[1]),
    .ld_valid(ld_valid[1]), .ld_rd(ld_rd[1]), .ld_data(ld_data[1]), .ld_ready(ld_ready[1]),
    .iss_valid(iss_valid[1]), .iss_rd(iss_rd[1]),
    .chk_rs1(chk_rs1[1]), .chk_rs2(chk_rs2[1]), .chk_rs3(chk_rs3[1]), .chk_rd(chk_rd[1]),
    .hazard(hazard[1]), .F_WE(f_we[1]), .F_rd(f_rd[1]), .F_WD(f_wd[1]), .busy(busy[1])
  );

  typedef struct packed {
    logic [1:0]       fr, lr, hz;
    logic [1:0][31:0] bsy;
  } cexp_t;
  typedef struct packed {
    logic [1:0]       we;
    logic [1:0][4:0]  rd;
    logic [1:0][31:0] wd;
  } wexp_t;

  cexp_t exp_c[$];
  wexp_t exp_w[$];
  int    n_chk = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;

  // Model state: pending request per requester, busy set, last winner, held write.
  logic [1:0][31:0] m_busy, m_pfd, m_pld, m_hwd;
  logic [1:0][4:0]  m_pfrd, m_plrd, m_hrd, m_wrd;
  logic [1:0]       m_pf, m_pl, m_wwe, m_last_ld;

  bit          g_nf, g_nl, g_iss;
  logic [4:0]  g_frd, g_lrd, g_rs1, g_rs2, g_rs3, g_rd;
  logic [31:0] g_fd, g_ld;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic g_idle();
    g_nf = 0; g_nl = 0; g_iss = 0;
    g_frd = 0; g_lrd = 0; g_fd = 0; g_ld = 0;
    g_rs1 = 0; g_rs2 = 0; g_rs3 = 0; g_rd = 0;
  endtask

  task automatic zero_inputs();
    fpu_valid = '0; fpu_rd = '0; fpu_data = '0;
    ld_valid = '0; ld_rd = '0; ld_data = '0;
    iss_valid = '0; iss_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rs3 = '0; chk_rd = '0;
  endtask

  task automatic model_reset();
    m_busy = '0; m_pfd = '0; m_pld = '0; m_hwd = '0;
    m_pfrd = '0; m_plrd = '0; m_hrd = '0; m_wrd = '0;
    m_pf = '0; m_pl = '0; m_wwe = '0;
    m_last_ld = 2'b11;  // load "won last", so the FPU takes the first contention
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // Called at a negedge: present this cycle's inputs and record what must happen.
  task automatic drive_cycle();
    cexp_t ce;
    wexp_t we;
    logic  hz, iv, wf, wl;
    ce = '0;
    we = '0;
    for (int k = 0; k < 2; k++) begin
      if (!m_pf[k] && g_nf) begin m_pf[k] = 1; m_pfrd[k] = g_frd; m_pfd[k] = g_fd; end
      if (!m_pl[k] && g_nl) begin m_pl[k] = 1; m_plrd[k] = g_lrd; m_pld[k] = g_ld; end
      hz = m_busy[k][g_rs1] | m_busy[k][g_rs2] | m_busy[k][g_rs3] | m_busy[k][g_rd];
      iv = g_iss && !hz;
      if (m_pf[k] && m_pl[k]) wf = (k == 1) ? 1'b1 : m_last_ld[k];
      else                    wf = m_pf[k];
      wl = m_pl[k] && !wf;
      fpu_valid[k] = m_pf[k]; fpu_rd[k] = m_pfrd[k]; fpu_data[k] = m_pfd[k];
      ld_valid[k]  = m_pl[k]; ld_rd[k]  = m_plrd[k]; ld_data[k]  = m_pld[k];
      iss_valid[k] = iv; iss_rd[k] = g_rd;
      chk_rs1[k] = g_rs1; chk_rs2[k] = g_rs2; chk_rs3[k] = g_rs3; chk_rd[k] = g_rd;
      ce.fr[k] = wf; ce.lr[k] = wl; ce.hz[k] = hz; ce.bsy[k] = m_busy[k];
      if (wf) begin
        m_hrd[k] = m_pfrd[k]; m_hwd[k] = m_pfd[k]; m_pf[k] = 0; m_last_ld[k] = 0;
      end else if (wl) begin
        m_hrd[k] = m_plrd[k]; m_hwd[k] = m_pld[k]; m_pl[k] = 0; m_last_ld[k] = 1;
      end
      we.we[k] = wf | wl; we.rd[k] = m_hrd[k]; we.wd[k] = m_hwd[k];
      if (m_wwe[k]) m_busy[k][m_wrd[k]] = 1'b0;
      if (iv)       m_busy[k][g_rd]     = 1'b1;
      m_wwe[k] = wf | wl;
      m_wrd[k] = m_hrd[k];
    end
    exp_c.push_back(ce);
    exp_w.push_back(we);
  endtask

  task automatic step();
    drive_cycle();
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s k%0d F_WE", tag, k), f_we[k], 0);
      check($sformatf("%s k%0d F_rd", tag, k), f_rd[k], 0);
      check($sformatf("%s k%0d F_WD", tag, k), f_wd[k], 0);
      check($sformatf("%s k%0d busy", tag, k), busy[k], 0);
      check($sformatf("%s k%0d fpu_ready", tag, k), fpu_ready[k], 0);
      check($sformatf("%s k%0d ld_ready", tag, k), ld_ready[k], 0);
      check($sformatf("%s k%0d hazard", tag, k), hazard[k], 0);
    end
  endtask

  // Entered and left at a negedge; no clock edge passes before the checks.
  task automatic apply_reset();
    mon_en = 0;
    rst_n  = 0;
    zero_inputs();
    model_reset();
    exp_c.delete();
    exp_w.delete();
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst_n  = 1;
    mon_en = 1;
  endtask

  initial forever begin
    @(negedge clk); #2;
    if (mon_en) begin
      if (exp_c.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL comb_queue: got empty expected entry at %0t", $time);
      end else begin
        cexp_t e;
        e = exp_c.pop_front();
        for (int k = 0; k < 2; k++) begin
          check($sformatf("k%0d fpu_ready", k), fpu_ready[k], e.fr[k]);
          check($sformatf("k%0d ld_ready", k), ld_ready[k], e.lr[k]);
          check($sformatf("k%0d hazard", k), hazard[k], e.hz[k]);
          check($sformatf("k%0d busy", k), busy[k], e.bsy[k]);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (mon_en) begin
      if (exp_w.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL write_queue: got empty expected entry at %0t", $time);
      end else begin
        wexp_t e;
        e = exp_w.pop_front();
        for (int k = 0; k < 2; k++) begin
          check($sformatf("k%0d F_WE", k), f_we[k], e.we[k]);
          check($sformatf("k%0d F_rd", k), f_rd[k], e.rd[k]);
          check($sformatf("k%0d F_WD", k), f_wd[k], e.wd[k]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1;
    zero_inputs();
    g_idle();
    @(negedge clk);
    apply_reset();

    // lone FPU write, granted in the first cycle out of reset
    g_idle(); g_nf = 1; g_frd = 5; g_fd = 32'h3F80_0000; step();
    g_idle(); repeat (2) step();

    // both requesters for four cycles
    apply_reset();
    g_idle();
    g_nf = 1; g_frd = 1; g_fd = 32'h1111_1111;
    g_nl = 1; g_lrd = 2; g_ld = 32'h2222_2222;
    repeat (4) step();
    g_idle(); repeat (3) step();

    for (int c = 0; c < 400; c++) begin
      g_nf  = ($urandom_range(0, 3) != 0); g_frd = rnd_reg(); g_fd = $urandom();
      g_nl  = ($urandom_range(0, 2) != 0); g_lrd = rnd_reg(); g_ld = $urandom();
      g_iss = ($urandom_range(0, 1) != 0);
      g_rs1 = rnd_reg(); g_rs2 = rnd_reg(); g_rs3 = rnd_reg(); g_rd = rnd_reg();
      step();
    end
    g_idle(); repeat (3) step();

    // RAW hazard held through the write cycle, released after
    apply_reset();
    g_idle(); g_iss = 1; g_rd = 7; step();
    g_idle(); g_rs2 = 7; g_nf = 1; g_frd = 7; g_fd = 32'h4000_0000; step();
    g_idle(); g_rs2 = 7; step();
    g_idle(); g_rs2 = 7; step();

    // issue to f9 while f9 is being written: stays busy
    g_idle(); g_nf = 1; g_frd = 9; g_fd = 32'h0000_0009; step();
    g_idle(); g_iss = 1; g_rd = 9; step();
    g_idle(); g_rs1 = 9; step();

    g_idle(); g_iss = 1; g_rd = 8;  step();
    g_idle(); g_iss = 1; g_rd = 10; step();
    g_idle(); g_iss = 1; g_rd = 11; step();
    g_idle(); g_nf = 1; g_frd = 3; g_fd = 32'hDEAD_0003; step();

    // mid-cycle reset with a write on the port and a new transfer accepted
    g_idle(); g_nf = 1; g_frd = 4; g_fd = 32'hDEAD_0004; g_rs1 = 9;
    drive_cycle();
    #3;
    mon_en = 0;
    exp_w.delete();
    exp_c.delete();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pre-reset k%0d busy", k), busy[k], 32'h0000_0F00);
      check($sformatf("pre-reset k%0d F_WE", k), f_we[k], 1);
      check($sformatf("pre-reset k%0d fpu_ready", k), fpu_ready[k], 1);
    end
    rst_n = 0;
    #1;
    reset_checks("async");
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) check($sformatf("held k%0d F_WE", k), f_we[k], 0);
    @(negedge clk);
    zero_inputs();
    rst_n = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("post-reset k%0d F_WE", k), f_we[k], 0);
      check($sformatf("post-reset k%0d busy", k), busy[k], 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed FPU priority.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports fpu_valid in 1, fpu_rd in 5, fpu_data in 32, fpu_ready out 1: FPU result write request.
REQ-005 SHALL have ports ld_valid in 1, ld_rd in 5, ld_data in 32, ld_ready out 1: FP load (FLW) write request.
REQ-006 SHALL have ports iss_valid in 1, iss_rd in 5: decode issues an FP-writing instruction, destination iss_rd.
REQ-007 SHALL have ports chk_rs1, chk_rs2, chk_rs3, chk_rd, each in 5: operands/destination of the instruction in decode.
REQ-008 SHALL have port hazard, out 1: decode must stall.
REQ-009 SHALL have ports F_WE out 1, F_rd out 5, F_WD out 32: registered FP register-file write port.
REQ-010 SHALL have port busy, out 32: scoreboard bit per FP register.

Function
REQ-011 Request handshake SHALL be valid/ready; a transfer occurs in a cycle with valid=1 and ready=1.
REQ-012 Requesters SHALL hold valid, rd and data stable until transfer; the block need not tolerate withdrawal.
REQ-013 ready SHALL be combinational from the valid inputs and the pointer, with at most one of fpu_ready/ld_ready high per cycle.
REQ-014 Single request valid SHALL be granted in the same cycle.
REQ-015 With both valid and RR_EN=1, the grant SHALL go to the requester not granted most recently; 1-bit pointer last_fpu updated on every transfer.
REQ-016 With both valid and RR_EN=0, FPU SHALL always win.
REQ-017 On a transfer, the next posedge SHALL register F_WE=1, F_rd=granted rd, F_WD=granted data; with no transfer, F_WE=0.
REQ-018 Latency request-to-F_WE SHALL be exactly 1 cycle; throughput SHALL be 1 write per cycle, with no bubbles between back-to-back grants.
REQ-019 F_rd/F_WD SHALL hold last values while F_WE=0.
REQ-020 Scoreboard: iss_valid=1 SHALL set busy[iss_rd] at posedge.
REQ-021 Scoreboard: F_WE=1 SHALL clear busy[F_rd] at the same posedge the register file captures the write.
REQ-022 Set and clear of the same register in one cycle: set SHALL win (busy stays 1).
REQ-023 f0 SHALL be treated as an ordinary register (no hardwired-zero exemption).
REQ-024 hazard SHALL be combinational: busy[chk_rs1] | busy[chk_rs2] | busy[chk_rs3] | busy[chk_rd] (RAW and WAW).
REQ-025 hazard SHALL NOT be bypassed by a write in flight: a register whose F_WE is high this cycle still reads busy=1 until the edge.
REQ-026 Decode SHALL NOT assert iss_valid while hazard=1; behaviour otherwise is undefined and is not checked.

Reset
REQ-027 rst_n low SHALL immediately, asynchronously, force F_WE=0, F_rd=0, F_WD=0, busy=0, and last_fpu=0 (so FPU wins first contention), independent of clk.
REQ-028 During reset, fpu_ready and ld_ready SHALL be 0, and hazard SHALL be 0.
REQ-029 Reset mid-operation SHALL discard any accepted-but-unwritten request, with no F_WE pulse after rst_n deasserts unless a new transfer occurs.
REQ-030 The first transfer SHALL be possible in the first cycle with rst_n high.

Verification
REQ-031 Scenario: fpu_valid=1, rd=5, data=0x3F800000 alone -> fpu_ready=1 same cycle; next cycle F_WE=1, F_rd=5, F_WD=0x3F800000.
REQ-032 Scenario: both valid 4 cycles (fpu rd=1, ld rd=2), RR_EN=1, post-reset -> grants F,L,F,L; F_rd sequence 1,2,1,2, with no F_WE gaps.
REQ-033 Scenario: same stimulus, RR_EN=0 -> four FPU grants; ld_ready stays 0.
REQ-034 Scenario: iss_valid rd=7; next cycle chk_rs2=7 -> hazard=1; hazard stays 1 through the F_WE cycle for rd=7; hazard=0 the cycle after.
REQ-035 Scenario: iss_valid rd=9 in the same cycle F_WE=1 with F_rd=9 -> busy[9]=1 afterwards.
REQ-036 Scenario: rst_n pulsed low mid-cycle while a transfer is accepted and busy=0x0000_0F00 -> F_WE=0 and busy=0 immediately; no F_WE on the following edge.
